// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one conditional subtract per clock,
// WIDTH iterations per division, start/busy/done handshake.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_dbz;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;

   logic [2*WIDTH-1:0] w_step;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;

   // One restoring iteration. The partial remainder stays below the divisor,
   // so the shifted value always fits in WIDTH+1 bits and a negative trial
   // leaves a shifted remainder that still fits in WIDTH bits.
   function automatic logic [2*WIDTH-1:0] restore_step(
      input logic [WIDTH-1:0] rem,
      input logic [WIDTH-1:0] quo,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] trial;
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[WIDTH]) begin
         restore_step = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
      end else begin
         restore_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
      end
   endfunction

   assign w_step    = restore_step(r_rem, r_quo, r_div);
   assign w_rem_nxt = w_step[2*WIDTH-1:WIDTH];
   assign w_quo_nxt = w_step[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_q_out <= '0;
         r_r_out <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               if (divisor != '0) begin
                  r_state <= S_RUN;
                  r_rem   <= '0;
                  r_quo   <= dividend;
                  r_div   <= divisor;
                  r_cnt   <= '0;
                  r_dbz   <= 1'b0;
               end else begin
                  // Divide-by-zero completes immediately without entering RUN.
                  r_done  <= 1'b1;
                  r_dbz   <= 1'b1;
                  r_q_out <= '1;
                  r_r_out <= dividend;
               end
            end
         end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ITER) begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
               r_dbz   <= 1'b0;
               r_q_out <= w_quo_nxt;
               r_r_out <= w_rem_nxt;
            end
         end
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign quotient    = r_q_out;
   assign remainder   = r_r_out;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8): expected results are
// queued at launch and popped when done pulses.
module tb_seq_restoring_divider;

   localparam int W = 8;
   localparam int LIMIT = 40;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; dividend = a; divisor = b;
      sb.push_back(model(a, b));
      step();
      start = 1'b0;
   endtask

   task automatic run_to_done(output int cyc, output int bcnt, output bit tmo);
      cyc = 0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && cyc < LIMIT) begin
         step();
         cyc++;
         if (busy === 1'b1) bcnt++;
      end
      tmo = (done !== 1'b1);
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      ok = (sb.size() != 0);
      e = '0;
      if (ok) e = sb.pop_front();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      step(); step();
      n_tests++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero});
      end
      n_tests++;
      if (quotient !== '0 || remainder !== '0) begin
         n_fail++; $display("FAIL reset_result got q=%0d r=%0d exp 0/0", quotient, remainder);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int cyc, bcnt; bit tmo, ok; exp_t e;
      launch(8'd100, 8'd7);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_accept got %b exp 1", busy); end
      run_to_done(cyc, bcnt, tmo);
      n_tests++;
      if (tmo || cyc != W) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d (timeout=%0d)", cyc, W, tmo); end
      n_tests++;
      if (bcnt != W) begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp %0d", bcnt, W); end
      pop_exp(e, ok);
      n_tests++;
      if (!ok || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || e.q !== 8'd14 || e.r !== 8'd2) begin
         n_fail++; $display("FAIL basic_result got q=%0d r=%0d dbz=%b exp q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
      end
      step();
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
      n_tests++;
      if (quotient !== 8'd14 || remainder !== 8'd2) begin
         n_fail++; $display("FAIL basic_hold got q=%0d r=%0d exp 14/2", quotient, remainder);
      end
   endtask

   task automatic test_div_zero();
      bit ok; exp_t e;
      launch(8'd5, 8'd0);
      pop_exp(e, ok);
      n_tests++;
      if (!ok || done !== 1'b1 || div_by_zero !== 1'b1 || quotient !== e.q || remainder !== e.r || busy !== 1'b0) begin
         n_fail++; $display("FAIL dbz_result got done=%b dbz=%b q=%0d r=%0d busy=%b exp 1 1 255 5 0",
                            done, div_by_zero, quotient, remainder, busy);
      end
      step();
      n_tests++;
      if (done !== 1'b0 || div_by_zero !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL dbz_after got done=%b dbz=%b busy=%b exp 0 1 0", done, div_by_zero, busy);
      end
   endtask

   task automatic test_edges();
      logic [W-1:0] ta [3] = '{8'd3, 8'd255, 8'd255};
      logic [W-1:0] tb [3] = '{8'd10, 8'd1, 8'd255};
      logic [W-1:0] tq [3] = '{8'd0, 8'd255, 8'd1};
      logic [W-1:0] tr [3] = '{8'd3, 8'd0, 8'd0};
      for (int i = 0; i < 3; i++) begin
         int cyc, bcnt; bit tmo, ok; exp_t e;
         launch(ta[i], tb[i]);
         if (i == 0) begin
            n_tests++;
            if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL edge_dbz_clear got %b exp 0", div_by_zero); end
         end
         run_to_done(cyc, bcnt, tmo);
         pop_exp(e, ok);
         n_tests++;
         if (tmo || !ok || quotient !== e.q || remainder !== e.r || quotient !== tq[i] || remainder !== tr[i]) begin
            n_fail++; $display("FAIL edge_%0d got q=%0d r=%0d exp q=%0d r=%0d", i, quotient, remainder, tq[i], tr[i]);
         end
         step();
      end
   endtask

   task automatic test_ignore_busy();
      int cyc, bcnt, extra; bit tmo, ok; exp_t e;
      logic [W-1:0] prev_q, prev_r;
      prev_q = quotient; prev_r = remainder;
      launch(8'd200, 8'd9);
      step(); step();
      start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      step();
      start = 1'b0;
      n_tests++;
      if (quotient !== prev_q || remainder !== prev_r) begin
         n_fail++; $display("FAIL ignore_hold_during_run got q=%0d r=%0d exp q=%0d r=%0d", quotient, remainder, prev_q, prev_r);
      end
      run_to_done(cyc, bcnt, tmo);
      pop_exp(e, ok);
      n_tests++;
      if (tmo || !ok || quotient !== e.q || remainder !== e.r || quotient !== 8'd22 || remainder !== 8'd2) begin
         n_fail++; $display("FAIL ignore_result got q=%0d r=%0d exp 22/2", quotient, remainder);
      end
      extra = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin n_fail++; $display("FAIL ignore_extra_activity got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      int cyc, bcnt, extra; bit tmo, ok; exp_t e;
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      step();
      start = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
         n_fail++; $display("FAIL midreset_state got busy=%b done=%b q=%0d r=%0d exp 0 0 0 0", busy, done, quotient, remainder);
      end
      rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step();
         if (done === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin n_fail++; $display("FAIL midreset_late_done got %0d exp 0", extra); end
      launch(8'd9, 8'd4);
      run_to_done(cyc, bcnt, tmo);
      pop_exp(e, ok);
      n_tests++;
      if (tmo || !ok || quotient !== e.q || remainder !== e.r || quotient !== 8'd2 || remainder !== 8'd1) begin
         n_fail++; $display("FAIL midreset_after got q=%0d r=%0d exp 2/1", quotient, remainder);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int cyc1, cyc2, bcnt; bit tmo, ok; exp_t e;
      start = 1'b1; dividend = 8'd60; divisor = 8'd7;
      sb.push_back(model(8'd60, 8'd7));
      step();
      dividend = 8'd61;
      sb.push_back(model(8'd61, 8'd7));
      run_to_done(cyc1, bcnt, tmo);
      pop_exp(e, ok);
      n_tests++;
      if (tmo || !ok || cyc1 != W || quotient !== e.q || remainder !== e.r || quotient !== 8'd8 || remainder !== 8'd4) begin
         n_fail++; $display("FAIL b2b_first got q=%0d r=%0d lat=%0d exp 8/4 lat=%0d", quotient, remainder, cyc1, W);
      end
      step();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done);
      end
      run_to_done(cyc2, bcnt, tmo);
      pop_exp(e, ok);
      n_tests++;
      if (tmo || !ok || cyc2 != W || quotient !== e.q || remainder !== e.r || quotient !== 8'd8 || remainder !== 8'd5) begin
         n_fail++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d exp 8/5 lat=%0d", quotient, remainder, cyc2, W);
      end
      n_tests++;
      if (cyc2 + 1 != W + 1) begin
         n_fail++; $display("FAIL b2b_spacing got %0d exp %0d", cyc2 + 1, W + 1);
      end
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 2000; n++) begin
         int cyc, bcnt; bit tmo, ok; exp_t e;
         logic [W-1:0] a, b;
         a = W'($urandom_range(0, 255));
         case ($urandom_range(0, 9))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 4));
            default: b = W'($urandom_range(1, 255));
         endcase
         launch(a, b);
         run_to_done(cyc, bcnt, tmo);
         pop_exp(e, ok);
         n_tests++;
         if (tmo || !ok || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz ||
             (b != 0 && (16'(quotient) * 16'(b) + 16'(remainder) != 16'(a) || remainder >= b))) begin
            n_fail++; $display("FAIL rand_%0d a=%0d b=%0d got q=%0d r=%0d dbz=%b exp q=%0d r=%0d dbz=%b",
                               n, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
         end
         if (tmo) begin
            $display("FAIL rand_timeout at op %0d", n);
            $fatal(1, "divider did not complete");
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_edges();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
